uart_rx_fifo_gen2: RTL and testbench

Parametrised next-generation asynchronous UART receiver with an integrated first-word-fall-through RX FIFO.
- Data width is selectable at run time from 5 to DATA_MAX bits. Oversampling ratio and FIFO depth are set by parameters.
- Supports optional parity, 1 or 2 stop bits, false-start rejection and break detection.
- Sits between the pin synchroniser/baud generator and the APB register block. Replaces the fixed 7/8-bit receiver.

---
 rtl/uart_rx_fifo_gen2.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo_gen2.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_gen2.sv
// UART receiver with run-time data width, optional parity, 1/2 stop bits,
// false-start rejection, break detection and a first-word-fall-through RX FIFO.
module uart_rx_fifo_gen2 #(
  parameter int DATA_MAX   = 9,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        baud_clock,
  input  logic                        rx,
  input  logic [3:0]                  data_bits,
  input  logic                        parity_en,
  input  logic                        odd_n_even,
  input  logic                        two_stop,
  input  logic                        rd_en,
  input  logic                        clear_errors,
  output logic [DATA_MAX-1:0]         rx_data,
  output logic                        rx_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        framing_error,
  output logic                        break_det,
  output logic                        rx_idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [3:0]    NB_MAX   = 4'(DATA_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRKWAIT
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            samp_q, samp_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [3:0]            bit_q, bit_d;
  logic [3:0]            nbits_q, nbits_d;
  logic                  pe_q, pe_d, odd_q, odd_d, ts_q, ts_d;
  logic [DATA_MAX-1:0]   shreg_q, shreg_d;
  logic                  xor_q, xor_d, pbit_q, pbit_d;
  logic                  ovf_q, ovf_d, par_q, par_d, frm_q, frm_d, brk_q, brk_d;
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_MAX-1:0]   mem_q [FIFO_DEPTH];

  logic       rx_f, mid, wr_req, set_par, set_frm, set_brk;
  logic       empty, full, push, pop, set_ovf;
  logic [3:0] nb_clamp;

  always_comb begin
    rx_f = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    mid  = (tick_q == T_MID);
    if (data_bits < 4'd5)        nb_clamp = 4'd5;
    else if (data_bits > NB_MAX) nb_clamp = NB_MAX;
    else                         nb_clamp = data_bits;
  end

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    nbits_d = nbits_q;
    pe_d    = pe_q;
    odd_d   = odd_q;
    ts_d    = ts_q;
    shreg_d = shreg_q;
    xor_d   = xor_q;
    pbit_d  = pbit_q;
    wr_req  = 1'b0;
    set_par = 1'b0;
    set_frm = 1'b0;
    set_brk = 1'b0;
    if (baud_clock) begin
      samp_d = {samp_q[1:0], rx};
      case (state_q)
        S_IDLE: if (!rx_f) begin
          state_d = S_START;
          tick_d  = '0;
          nbits_d = nb_clamp;
          pe_d    = parity_en;
          odd_d   = odd_n_even;
          ts_d    = two_stop;
        end
        S_START: begin
          if (rx_f) state_d = S_IDLE;
          else if (tick_q == T_HALF) begin
            state_d = S_DATA;
            tick_d  = '0;
            bit_d   = '0;
            shreg_d = '0;
            xor_d   = 1'b0;
          end else tick_d = tick_q + 1'b1;
        end
        S_DATA: begin
          tick_d = tick_q + 1'b1;
          if (mid) begin
            tick_d         = '0;
            shreg_d[bit_q] = rx_f;
            xor_d          = xor_q ^ rx_f;
            if (bit_q == nbits_q - 4'd1) state_d = pe_q ? S_PARITY : S_STOP1;
            else                         bit_d   = bit_q + 4'd1;
          end
        end
        S_PARITY: begin
          tick_d = tick_q + 1'b1;
          if (mid) begin
            tick_d  = '0;
            pbit_d  = rx_f;
            state_d = S_STOP1;
          end
        end
        S_STOP1: begin
          tick_d = tick_q + 1'b1;
          if (mid) begin
            tick_d = '0;
            // An all-zero character (including parity) with a low stop bit is a break.
            if (!rx_f && (shreg_q == '0) && !(pe_q && pbit_q)) begin
              set_brk = 1'b1;
              state_d = S_BRKWAIT;
            end else begin
              set_frm = !rx_f;
              wr_req  = 1'b1;
              set_par = pe_q && ((xor_q ^ pbit_q) != odd_q);
              state_d = ts_q ? S_STOP2 : S_IDLE;
            end
          end
        end
        S_STOP2: begin
          tick_d = tick_q + 1'b1;
          if (mid) begin
            tick_d  = '0;
            set_frm = !rx_f;
            state_d = S_IDLE;
          end
        end
        S_BRKWAIT: if (rx_f) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Simultaneous pop lets a write into a full FIFO complete.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    pop     = rd_en && !empty;
    push    = wr_req && (!full || pop);
    set_ovf = wr_req && full && !pop;
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = set_ovf | (ovf_q & ~clear_errors);
    par_d = set_par | (par_q & ~clear_errors);
    frm_d = set_frm | (frm_q & ~clear_errors);
    brk_d = set_brk | (brk_q & ~clear_errors);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      samp_q  <= 3'b111;
      tick_q  <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      pe_q    <= 1'b0;
      odd_q   <= 1'b0;
      ts_q    <= 1'b0;
      shreg_q <= '0;
      xor_q   <= 1'b0;
      pbit_q  <= 1'b0;
      ovf_q   <= 1'b0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
      brk_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      pe_q    <= pe_d;
      odd_q   <= odd_d;
      ts_q    <= ts_d;
      shreg_q <= shreg_d;
      xor_q   <= xor_d;
      pbit_q  <= pbit_d;
      ovf_q   <= ovf_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
      brk_q   <= brk_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= shreg_q;
  end

  assign rx_data       = empty ? '0 : mem_q[rptr_q];
  assign rx_valid      = !empty;
  assign fifo_count    = count_q;
  assign overflow      = ovf_q;
  assign parity_err    = par_q;
  assign framing_error = frm_q;
  assign break_det     = brk_q;
  assign rx_idle       = (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo_gen2.sv
// Directed plus randomized bench for uart_rx_fifo_gen2 against a queue-based
// character/flag model derived from the frame rules.
module tb_uart_rx_fifo_gen2;
  localparam int DM = 9, OS = 16, FD = 8;

  logic          clk = 1'b0, reset_n = 1'b0, rx = 1'b1;
  logic          baud_clock;
  logic [3:0]    data_bits = 4'd8;
  logic          parity_en = 1'b0, odd_n_even = 1'b0, two_stop = 1'b0;
  logic          rd_en = 1'b0, clear_errors = 1'b0;
  logic [DM-1:0] rx_data;
  logic          rx_valid, overflow, parity_err, framing_error, break_det, rx_idle;
  logic [$clog2(FD):0] fifo_count;

  int n_assert = 0, n_fail = 0;
  int bcnt = 0;

  logic [DM-1:0] q[$];
  bit m_ovf, m_par, m_frm, m_brk;

  uart_rx_fifo_gen2 #(.DATA_MAX(DM), .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
    .data_bits(data_bits), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .two_stop(two_stop), .rd_en(rd_en), .clear_errors(clear_errors),
    .rx_data(rx_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
    .overflow(overflow), .parity_err(parity_err), .framing_error(framing_error),
    .break_det(break_det), .rx_idle(rx_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bcnt <= (bcnt == 2) ? 0 : bcnt + 1;
  assign baud_clock = (bcnt == 2);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns on the negedge preceding a clock edge that carries a baud pulse.
  task automatic wait_tick();
    do @(negedge clk); while (baud_clock !== 1'b1);
  endtask

  function automatic int clampnb(input int r);
    if (r < 5) return 5;
    if (r > DM) return DM;
    return r;
  endfunction

  // probe 1: the write lands on the stop-bit mid tick; probe 2: pop on that very edge.
  task automatic drive_bit(input bit b, input int probe, input bit is_start);
    for (int k = 0; k < OS; k++) begin
      wait_tick();
      if (k == 0) rx = b;
      if (is_start && k == 4) begin
        data_bits  = 4'($urandom);
        parity_en  = 1'($urandom);
        odd_n_even = 1'($urandom);
        two_stop   = 1'($urandom);
      end
      if (probe == 1 && k == 10) begin
        chk("valid_before_mid", rx_valid, 0);
        @(negedge clk);
        chk("valid_at_mid", rx_valid, 1);
      end
      if (probe == 2 && k == 10) begin
        chk("head_before_popwrite", rx_data, q[0]);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(q.pop_front());
      end
    end
  endtask

  task automatic send_frame(input int raw_nb, input bit pe, input bit odd, input bit ts,
                            input int ch, input bit wrong_par, input bit s1, input bit s2,
                            input int probe);
    int nb;
    logic [DM-1:0] chm;
    bit pbit;
    nb   = clampnb(raw_nb);
    chm  = DM'(ch & ((1 << nb) - 1));
    pbit = bit'(($countones(chm) % 2) ^ int'(odd) ^ int'(wrong_par));
    data_bits = 4'(raw_nb); parity_en = pe; odd_n_even = odd; two_stop = ts;
    drive_bit(1'b0, 0, 1'b1);
    for (int i = 0; i < nb; i++) drive_bit(chm[i], 0, 1'b0);
    if (pe) drive_bit(pbit, 0, 1'b0);
    drive_bit(s1, probe, 1'b0);
    if (ts) drive_bit(s2, 0, 1'b0);
    drive_bit(1'b1, 0, 1'b0);
    drive_bit(1'b1, 0, 1'b0);
    if (!s1 && chm == 0 && (!pe || !pbit)) m_brk = 1;
    else begin
      if (!s1) m_frm = 1;
      if (ts && !s2) m_frm = 1;
      if (pe && wrong_par) m_par = 1;
      if (q.size() < FD) q.push_back(chm);
      else m_ovf = 1;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, fifo_count, q.size());
    chk({tag, "_valid"}, rx_valid, q.size() != 0);
    if (q.size() != 0) chk({tag, "_data"}, rx_data, q[0]);
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_par"}, parity_err, m_par);
    chk({tag, "_frm"}, framing_error, m_frm);
    chk({tag, "_brk"}, break_det, m_brk);
    chk({tag, "_idle"}, rx_idle, 1);
  endtask

  task automatic pop(input string tag);
    if (q.size() != 0) chk({tag, "_head"}, rx_data, q[0]);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk({tag, "_cnt_after_pop"}, fifo_count, q.size());
  endtask

  task automatic clr();
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    m_ovf = 0; m_par = 0; m_frm = 0; m_brk = 0;
  endtask

  task automatic hold_ticks(input bit b, input int n);
    for (int k = 0; k < n; k++) begin
      wait_tick();
      if (k == 0) rx = b;
    end
  endtask

  initial begin
    bit stayed;
    repeat (4) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_flags", {overflow, parity_err, framing_error, break_det}, 0);
    chk("rst_idle", rx_idle, 1);
    reset_n = 1'b1;
    hold_ticks(1'b1, 32);

    send_frame(8, 0, 0, 0, 'hA5, 0, 1, 1, 1);
    check_status("8n1");
    chk("8n1_value", rx_data, 'h0A5);
    pop("8n1");
    chk("8n1_empty", rx_valid, 0);

    send_frame(7, 1, 0, 0, 'h41, 1, 1, 1, 0);
    check_status("7e1_bad");
    chk("7e1_bad_value", rx_data, 'h041);
    clr();
    check_status("7e1_clr");
    send_frame(7, 1, 1, 0, 'h41, 0, 1, 1, 0);
    check_status("7o1_ok");
    pop("7e1_a");
    pop("7e1_b");

    send_frame(9, 0, 0, 1, 'h1FF, 0, 1, 0, 0);
    check_status("9n2_frm");
    chk("9n2_value", rx_data, 'h1FF);
    pop("9n2");
    clr();

    hold_ticks(1'b0, 5);
    hold_ticks(1'b1, 32);
    check_status("glitch5");
    stayed = 1;
    hold_ticks(1'b0, 1);
    for (int k = 0; k < 16; k++) begin
      wait_tick();
      rx = 1'b1;
      if (rx_idle !== 1'b1) stayed = 0;
    end
    chk("glitch1_idle_held", stayed, 1);

    for (int i = 0; i <= FD; i++) send_frame(8, 0, 0, 0, i, 0, 1, 1, 0);
    check_status("ovf");
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < FD; i++) begin
      chk("ovf_order", rx_data, i);
      pop("ovf_rd");
    end
    chk("ovf_drained", rx_valid, 0);
    clr();

    for (int i = 0; i < FD; i++) send_frame(8, 0, 0, 0, 'h10 + i, 0, 1, 1, 0);
    send_frame(8, 0, 0, 0, 'h55, 0, 1, 1, 2);
    check_status("popwr");
    chk("popwr_count", fifo_count, FD);
    chk("popwr_noovf", overflow, 0);
    for (int i = 0; i < FD; i++) pop("popwr_rd");
    chk("popwr_last", rx_valid, 0);

    data_bits = 4'd8; parity_en = 0; two_stop = 0;
    hold_ticks(1'b0, 24 * OS);
    hold_ticks(1'b1, 32);
    m_brk = 1;
    check_status("break");
    send_frame(8, 0, 0, 0, 'h3C, 0, 1, 1, 0);
    check_status("after_break");
    pop("after_break");
    clr();

    for (int it = 0; it < 20; it++) begin
      send_frame($urandom_range(2, 15), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 0);
      check_status("rand");
      for (int p = $urandom_range(0, 2); p > 0; p--) pop("rand");
      if ($urandom_range(0, 3) == 0) begin
        clr();
        check_status("rand_clr");
      end
    end
    while (q.size() != 0) pop("drain");
    clr();

    send_frame(8, 1, 0, 0, 'h33, 1, 1, 1, 0);
    check_status("pre_reset");
    data_bits = 4'd8; parity_en = 0;
    drive_bit(1'b0, 0, 1'b1);
    drive_bit(1'b1, 0, 1'b0);
    drive_bit(1'b0, 0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_data", rx_data, 0);
    chk("midrst_flags", {overflow, parity_err, framing_error, break_det}, 0);
    chk("midrst_idle", rx_idle, 1);
    q.delete();
    m_ovf = 0; m_par = 0; m_frm = 0; m_brk = 0;
    rx = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    hold_ticks(1'b1, 32);
    check_status("post_reset_idle");
    send_frame(8, 0, 0, 0, 'hC3, 0, 1, 1, 0);
    check_status("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
